// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit with req/ack data-memory handshake
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        EX_Valid,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [1:0]  EX_MemSize,
    input  logic        EX_MemSigned,
    input  logic        EX_RegWrite,
    input  logic        EX_CondMov,
    input  logic        EX_ZeroFlag,
    input  logic [31:0] EX_ALUResult,
    input  logic [31:0] EX_WriteData,
    input  logic [4:0]  EX_WriteRegister,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_BE,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic        Stall,
    output logic        MEM_RegWrite,
    output logic        MEM_CondMov,
    output logic        MEM_ZeroFlag,
    output logic [31:0] MEM_ALUResult,
    output logic [4:0]  MEM_WriteRegister,
    output logic        MisalignErr,
    output logic        BusErr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last REQ cycle (counted from 0) that may still wait for an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic        timeout_q, timeout_d;

    logic        is_mem_op;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_data;
    logic        stall_c;
    logic        misalign_c;
    logic        bus_c;
    logic        mem_rw_c;
    logic [31:0] mem_alu_c;

    // Decode the EX/MEM op: alignment and store byte-lane placement.
    always_comb begin
        is_mem_op  = EX_Valid & (EX_MemRead | EX_MemWrite);
        misaligned = ((EX_MemSize == 2'b01) & EX_ALUResult[0]) |
                     (EX_MemSize[1] & (EX_ALUResult[1:0] != 2'b00));
        lane_be    = 4'b1111;
        lane_wdata = EX_WriteData;
        case (EX_MemSize)
            2'b00: begin
                lane_be    = 4'b0001 << EX_ALUResult[1:0];
                lane_wdata = {4{EX_WriteData[7:0]}};
            end
            2'b01: begin
                lane_be    = EX_ALUResult[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{EX_WriteData[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = EX_WriteData;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        case (EX_ALUResult[1:0])
            2'b00:   lane8 = Mem_RData[7:0];
            2'b01:   lane8 = Mem_RData[15:8];
            2'b10:   lane8 = Mem_RData[23:16];
            default: lane8 = Mem_RData[31:24];
        endcase
        lane16 = EX_ALUResult[1] ? Mem_RData[31:16] : Mem_RData[15:0];
        case (EX_MemSize)
            2'b00:   load_data = {{24{EX_MemSigned & lane8[7]}}, lane8};
            2'b01:   load_data = {{16{EX_MemSigned & lane16[15]}}, lane16};
            default: load_data = Mem_RData;
        endcase
    end

    // Access FSM: next state, request registers and MEM/WB-facing outputs.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wait_cnt_d  = wait_cnt_q;
        load_buf_d  = load_buf_q;
        timeout_d   = timeout_q;
        stall_c     = 1'b0;
        misalign_c  = 1'b0;
        bus_c       = 1'b0;
        mem_rw_c    = EX_Valid & EX_RegWrite;
        mem_alu_c   = EX_ALUResult;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                timeout_d  = 1'b0;
                if (is_mem_op) begin
                    if (misaligned) begin
                        misalign_c = 1'b1;
                        mem_rw_c   = 1'b0;
                    end else begin
                        stall_c     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = EX_MemWrite;
                        mem_addr_d  = {EX_ALUResult[31:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (Mem_Ack) begin
                    if (!mem_we_q) begin
                        load_buf_d = load_data;
                    end
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (!mem_we_q) begin
                    mem_alu_c = load_buf_q;
                end
                if (timeout_q) begin
                    mem_rw_c = 1'b0;
                    bus_c    = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset abandons any outstanding access.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            wait_cnt_q  <= 8'd0;
            load_buf_q  <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wait_cnt_q  <= wait_cnt_d;
            load_buf_q  <= load_buf_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Mem_Req           = mem_req_q;
    assign Mem_We            = mem_we_q;
    assign Mem_Addr          = mem_addr_q;
    assign Mem_WData         = mem_wdata_q;
    assign Mem_BE            = mem_be_q;
    assign Stall             = Rst & stall_c;
    assign MisalignErr       = Rst & misalign_c;
    assign BusErr            = Rst & bus_c;
    assign MEM_RegWrite      = mem_rw_c;
    assign MEM_CondMov       = EX_CondMov;
    assign MEM_ZeroFlag      = EX_ZeroFlag;
    assign MEM_ALUResult     = mem_alu_c;
    assign MEM_WriteRegister = EX_WriteRegister;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
    localparam int MW = 4;

    logic        Clk, Rst;
    logic        EX_Valid, EX_MemRead, EX_MemWrite, EX_MemSigned;
    logic [1:0]  EX_MemSize;
    logic        EX_RegWrite, EX_CondMov, EX_ZeroFlag;
    logic [31:0] EX_ALUResult, EX_WriteData;
    logic [4:0]  EX_WriteRegister;
    logic        Mem_Req, Mem_We;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
    logic [3:0]  Mem_BE;
    logic        Mem_Ack, Stall;
    logic        MEM_RegWrite, MEM_CondMov, MEM_ZeroFlag;
    logic [31:0] MEM_ALUResult;
    logic [4:0]  MEM_WriteRegister;
    logic        MisalignErr, BusErr;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.MAX_WAIT(MW)) dut (
        .Clk(Clk), .Rst(Rst),
        .EX_Valid(EX_Valid), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemSize(EX_MemSize), .EX_MemSigned(EX_MemSigned), .EX_RegWrite(EX_RegWrite),
        .EX_CondMov(EX_CondMov), .EX_ZeroFlag(EX_ZeroFlag), .EX_ALUResult(EX_ALUResult),
        .EX_WriteData(EX_WriteData), .EX_WriteRegister(EX_WriteRegister),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_BE(Mem_BE), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack), .Stall(Stall),
        .MEM_RegWrite(MEM_RegWrite), .MEM_CondMov(MEM_CondMov), .MEM_ZeroFlag(MEM_ZeroFlag),
        .MEM_ALUResult(MEM_ALUResult), .MEM_WriteRegister(MEM_WriteRegister),
        .MisalignErr(MisalignErr), .BusErr(BusErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        sgn, rw;
        logic [31:0] addr, wd, rdata;
        int          ack_delay;
    } op_t;

    typedef struct {
        logic        valid, rd, wr;
        logic [1:0]  size;
        logic        rw;
        logic [31:0] alu;
        logic        exp_mis, exp_rw;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic rw, input logic [31:0] alu, input logic [31:0] wd);
        EX_Valid = valid; EX_MemRead = rd; EX_MemWrite = wr; EX_MemSize = size;
        EX_MemSigned = sgn; EX_RegWrite = rw; EX_ALUResult = alu; EX_WriteData = wd;
        EX_CondMov = 1'($urandom); EX_ZeroFlag = 1'($urandom); EX_WriteRegister = 5'($urandom);
    endtask

    function automatic op_t mk_op(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                                  input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdata, input int ack_delay);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = size; o.sgn = sgn; o.rw = rw;
        o.addr = addr; o.wd = wd; o.rdata = rdata; o.ack_delay = ack_delay;
        return o;
    endfunction

    // Reference model: byte-lane arithmetic straight from the access rules.
    function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 4'(1 << (addr % 4));
        if (size == 2'd1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Drive one aligned memory op to completion, acting as the memory; observe only.
    task automatic run_access(input op_t op, output int stall_n, output int req_n,
                              output logic [31:0] addr_o, output logic [31:0] wdata_o,
                              output logic [3:0] be_o, output logic we_o, output logic stable_o,
                              output logic [31:0] alu_o, output logic rw_o, output logic bus_o,
                              output logic idle_busy_o, output logic done_o);
        stall_n = 0; req_n = 0; stable_o = 1'b1; done_o = 1'b0;
        addr_o = '0; wdata_o = '0; be_o = '0; we_o = 1'b0;
        alu_o = '0; rw_o = 1'b0; bus_o = 1'b0; idle_busy_o = 1'b0;
        set_ex(1'b1, op.rd, op.wr, op.size, op.sgn, op.rw, op.addr, op.wd);
        Mem_Ack = 1'b0;
        for (int cyc = 0; cyc < 64 && !done_o; cyc++) begin
            @(negedge Clk);
            if (Stall) begin
                stall_n++;
                if (Mem_Req) begin
                    if (req_n == 0) begin
                        addr_o = Mem_Addr; wdata_o = Mem_WData; be_o = Mem_BE; we_o = Mem_We;
                    end else if (Mem_Addr !== addr_o || Mem_WData !== wdata_o ||
                                 Mem_BE !== be_o || Mem_We !== we_o) begin
                        stable_o = 1'b0;
                    end
                    Mem_Ack   = (req_n == op.ack_delay);
                    Mem_RData = Mem_Ack ? op.rdata : $urandom;
                    req_n++;
                end
            end else begin
                done_o = 1'b1;
                alu_o = MEM_ALUResult; rw_o = MEM_RegWrite; bus_o = BusErr;
                Mem_Ack = 1'b1;
                Mem_RData = $urandom;
            end
            @(posedge Clk); #1;
            if (!done_o) Mem_Ack = 1'b0;
        end
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge Clk);
        idle_busy_o = Mem_Req | Stall | BusErr;
        Mem_Ack = 1'b0;
        @(posedge Clk); #1;
    endtask

    // Run an access and compare everything against the model.
    task automatic verify_access(input string tag, input op_t op, output int stall_n, output int req_n,
                                 output logic [31:0] alu_o);
        logic [31:0] addr_o, wdata_o;
        logic [3:0]  be_o;
        logic        we_o, stable_o, rw_o, bus_o, idle_busy_o, done_o;
        logic        tmo, is_load;
        run_access(op, stall_n, req_n, addr_o, wdata_o, be_o, we_o, stable_o, alu_o, rw_o, bus_o,
                   idle_busy_o, done_o);
        tmo = (op.ack_delay >= MW);
        is_load = !op.wr;
        check({tag, " completed"}, 32'(done_o), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_n), tmo ? 32'(MW + 1) : 32'(op.ack_delay + 2));
        check({tag, " req cycles"}, 32'(req_n), tmo ? 32'(MW) : 32'(op.ack_delay + 1));
        check({tag, " addr"}, addr_o, op.addr & 32'hFFFFFFFC);
        check({tag, " we"}, 32'(we_o), 32'(op.wr));
        check({tag, " req stable"}, 32'(stable_o), 32'd1);
        if (op.wr) begin
            check({tag, " be"}, 32'(be_o), 32'(m_be(op.size, op.addr)));
            check({tag, " wdata"}, wdata_o, m_wdata(op.size, op.wd));
        end
        if (!tmo)
            check({tag, " result"}, alu_o, is_load ? m_load(op.size, op.sgn, op.addr, op.rdata) : op.addr);
        check({tag, " regwrite"}, 32'(rw_o), tmo ? 32'd0 : 32'(op.rw));
        check({tag, " buserr"}, 32'(bus_o), 32'(tmo));
        check({tag, " idle after"}, 32'(idle_busy_o), 32'd0);
    endtask

    // Single-cycle IDLE op (pass-through or misaligned): nothing may be requested.
    task automatic verify_comb(input string tag, input logic valid, input logic rd, input logic wr,
                               input logic [1:0] size, input logic rw, input logic [31:0] alu,
                               input logic exp_mis, input logic exp_rw);
        set_ex(valid, rd, wr, size, 1'($urandom), rw, alu, $urandom);
        @(negedge Clk);
        check({tag, " stall"}, 32'(Stall), 32'd0);
        check({tag, " misalign"}, 32'(MisalignErr), 32'(exp_mis));
        check({tag, " regwrite"}, 32'(MEM_RegWrite), 32'(exp_rw));
        check({tag, " alu"}, MEM_ALUResult, alu);
        check({tag, " passthru"}, {25'd0, EX_CondMov, EX_ZeroFlag, EX_WriteRegister},
              {25'd0, MEM_CondMov, MEM_ZeroFlag, MEM_WriteRegister});
        @(posedge Clk); #1;
        check({tag, " no req"}, 32'(Mem_Req | Stall | BusErr), 32'd0);
    endtask

    vec_t vecs[8];
    int   sn, rn;
    logic [31:0] res;

    initial begin
        Rst = 1'b0; Mem_Ack = 1'b0; Mem_RData = 32'd0;
        set_ex(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h100, 32'd0);
        @(negedge Clk); @(negedge Clk);
        check("reset req", 32'(Mem_Req), 32'd0);
        check("reset we", 32'(Mem_We), 32'd0);
        check("reset addr", Mem_Addr, 32'd0);
        check("reset wdata", Mem_WData, 32'd0);
        check("reset be", 32'(Mem_BE), 32'd0);
        check("reset flags", {29'd0, Stall, MisalignErr, BusErr}, 32'd0);
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        Rst = 1'b1;
        @(posedge Clk); #1;

        //         valid rd  wr  size   rw  alu            mis rw
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_1234, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0105, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0201, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 32'h0000_0202, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0105, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            verify_comb($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].size,
                        vecs[i].rw, vecs[i].alu, vecs[i].exp_mis, vecs[i].exp_rw);

        verify_access("lb_signed", mk_op(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'h103, 32'd0, 32'h80FFFFFF, 0),
                      sn, rn, res);
        check("lb_signed const", res, 32'hFFFFFF80);
        check("lb_signed stall2", 32'(sn), 32'd2);

        verify_access("sh", mk_op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h202, 32'hABCD1234, 32'd0, 3),
                      sn, rn, res);
        check("sh stall5", 32'(sn), 32'd5);
        check("sh req4", 32'(rn), 32'd4);

        verify_access("lw_timeout", mk_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h40, 32'd0, 32'd0, 100),
                      sn, rn, res);
        check("lw_timeout req4", 32'(rn), 32'd4);

        // Reset in the second REQ cycle abandons the access.
        set_ex(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'd0);
        Mem_Ack = 1'b0;
        @(posedge Clk); @(posedge Clk); #2;
        check("pre-reset req", 32'(Mem_Req), 32'd1);
        Rst = 1'b0;
        #1;
        check("midreset req", 32'(Mem_Req), 32'd0);
        check("midreset stall", 32'(Stall), 32'd0);
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        verify_access("lhu_after_rst", mk_op(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0, 32'd0, 32'h0000FFFF, 0),
                      sn, rn, res);
        check("lhu const", res, 32'h0000FFFF);

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic        rd, wr, rw;
            logic [1:0]  size;
            logic [31:0] addr;
            int          dly;
            kind = $urandom_range(0, 9);
            rd   = 1'($urandom); wr = 1'($urandom); rw = 1'($urandom);
            size = 2'($urandom); addr = $urandom;
            if (!rd && !wr) rd = 1'b1;
            dly  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            if (kind < 2)
                verify_comb($sformatf("rnd%0d alu", i), 1'b1, 1'b0, 1'b0, size, rw, addr, 1'b0, rw);
            else if (kind == 2)
                verify_comb($sformatf("rnd%0d bubble", i), 1'b0, rd, wr, size, rw, addr, 1'b0, 1'b0);
            else if (m_misaligned(size, addr))
                verify_comb($sformatf("rnd%0d mis", i), 1'b1, rd, wr, size, rw, addr, 1'b1, 1'b0);
            else
                verify_access($sformatf("rnd%0d mem", i),
                              mk_op(rd, wr, size, 1'($urandom), rw, addr, $urandom, $urandom, dly),
                              sn, rn, res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
